// File: rtl/sram_cache_controller.sv
// -----------------------------------------------------------------------------
// sram_cache_controller
//
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits return data in the request
// cycle without stalling. Read misses and every write (hit or miss) go through
// the SRAM controller's request/ready handshake, and the pipeline is held by
// freeze until sram_ready arrives.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous reset, active low
//   wr_en, rd_en    MEM-stage store / load request (store wins if both set)
//   address         word-aligned byte address, held stable while frozen
//   write_data      store data
//   read_data       load data to writeback (0 when nothing is returned)
//   freeze          pipeline stall
//   sram_wr_en      write request to the SRAM controller (WRITE state)
//   sram_rd_en      read request to the SRAM controller (READ_MISS state)
//   sram_address    unmodified address; the SRAM controller applies its base
//   sram_write_data copy of write_data
//   sram_read_data  word returned by the SRAM controller
//   sram_ready      single-cycle completion pulse from the SRAM controller
// -----------------------------------------------------------------------------
module sram_cache_controller #(
    parameter logic [31:0] BASE_ADDR  = 32'd1024,
    parameter int          INDEX_BITS = 6,
    parameter int          TAG_BITS   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        freeze,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int SETS   = 1 << INDEX_BITS;
    localparam int TAG_LO = INDEX_BITS + 2;
    localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;

    logic [31:0]           offset_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  unused_offset_s;

    logic [SETS-1:0]       valid0_r;
    logic [SETS-1:0]       valid1_r;
    logic [SETS-1:0]       lru_r;        // index of the least-recently-used way
    logic [TAG_BITS-1:0]   tag0_r  [SETS];
    logic [TAG_BITS-1:0]   tag1_r  [SETS];
    logic [31:0]           data0_r [SETS];
    logic [31:0]           data1_r [SETS];

    logic                  hit0_s;
    logic                  hit1_s;
    logic                  hit_s;
    logic                  hit_way_s;
    logic [31:0]           hit_data_s;
    logic                  victim_s;
    logic                  write_hit_s;
    logic                  read_hit_s;
    logic                  fill_s;

    // Address decode relative to the data-memory base
    assign offset_s        = address - BASE_ADDR;
    assign index_s         = offset_s[INDEX_BITS+1:2];
    assign tag_s           = offset_s[TAG_HI:TAG_LO];
    assign unused_offset_s = ^{offset_s[31:TAG_HI+1], offset_s[1:0]};

    // Tag lookup; the two ways never both match, so way1 match alone picks the way
    assign hit0_s     = valid0_r[index_s] && (tag0_r[index_s] == tag_s);
    assign hit1_s     = valid1_r[index_s] && (tag1_r[index_s] == tag_s);
    assign hit_s      = hit0_s || hit1_s;
    assign hit_way_s  = hit1_s;
    assign hit_data_s = hit1_s ? data1_r[index_s] : data0_r[index_s];

    // Victim: first invalid way (way0 preferred), else the LRU way
    assign victim_s = !valid0_r[index_s] ? 1'b0 :
                      (!valid1_r[index_s] ? 1'b1 : lru_r[index_s]);

    assign write_hit_s = (state_r == IDLE) && wr_en && hit_s;
    assign read_hit_s  = (state_r == IDLE) && !wr_en && rd_en && hit_s;
    assign fill_s      = (state_r == READ_MISS) && sram_ready;

    // SRAM requests are Moore outputs of the state register, so they drop in
    // the IDLE cycle right after sram_ready
    assign sram_rd_en      = (state_r == READ_MISS);
    assign sram_wr_en      = (state_r == WRITE);
    assign sram_address    = address;
    assign sram_write_data = write_data;

    // State, valid and LRU registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            valid0_r <= {SETS{1'b0}};
            valid1_r <= {SETS{1'b0}};
            lru_r    <= {SETS{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (write_hit_s || read_hit_s) begin
                lru_r[index_s] <= ~hit_way_s;
            end else if (fill_s) begin
                lru_r[index_s] <= ~victim_s;
                if (victim_s) begin
                    valid1_r[index_s] <= 1'b1;
                end else begin
                    valid0_r[index_s] <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays; not cleared by reset, and never written while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && write_hit_s) begin
            if (hit_way_s) begin
                data1_r[index_s] <= write_data;
            end else begin
                data0_r[index_s] <= write_data;
            end
        end else if (rst && fill_s) begin
            if (victim_s) begin
                tag1_r[index_s]  <= tag_s;
                data1_r[index_s] <= sram_read_data;
            end else begin
                tag0_r[index_s]  <= tag_s;
                data0_r[index_s] <= sram_read_data;
            end
        end
    end

    // Next-state, freeze and read data; freeze falls in the sram_ready cycle
    always_comb begin
        next_state_s = state_r;
        freeze       = 1'b0;
        read_data    = 32'd0;
        case (state_r)
            IDLE: begin
                if (wr_en) begin
                    freeze       = 1'b1;
                    next_state_s = WRITE;
                end else if (rd_en) begin
                    if (hit_s) begin
                        read_data = hit_data_s;
                    end else begin
                        freeze       = 1'b1;
                        next_state_s = READ_MISS;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ_MISS: begin
                if (sram_ready) begin
                    read_data    = sram_read_data;
                    next_state_s = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    next_state_s = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_cache_controller
//
// Directed bench with a scoreboard. Each request pushes its hand-computed
// expected response into a queue; a monitor watching the falling edge pops
// and compares whenever a request completes (request active and freeze low).
// A small SRAM controller model answers requests after a fixed latency.
// -----------------------------------------------------------------------------
module tb_sram_cache_controller;

    localparam int LAT = 5;

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] data;
        bit          sram_rd;
        bit          sram_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          frozen;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        freeze;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;
    logic        model_ready;
    logic        spur_ready;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks;
    int          errors;

    assign sram_ready = model_ready | spur_ready;

    sram_cache_controller dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .freeze          (freeze),
        .sram_wr_en      (sram_wr_en),
        .sram_rd_en      (sram_rd_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // SRAM controller model: ready pulse LAT cycles after a request appears
    initial begin
        int cnt;
        cnt = 0;
        model_ready = 1'b0;
        sram_read_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (model_ready) begin
                model_ready = 1'b0;
                cnt = 0;
            end else if (rst && (sram_rd_en || sram_wr_en)) begin
                cnt = cnt + 1;
                if (cnt == LAT) begin
                    model_ready = 1'b1;
                    if (sram_wr_en) begin
                        mem[sram_address] = sram_write_data;
                    end else begin
                        sram_read_data = mem.exists(sram_address) ? mem[sram_address] : 32'd0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: tracks SRAM activity per request and scores each completion
    initial begin
        bit          seen_rd;
        bit          seen_wr;
        logic [31:0] last_addr;
        logic [31:0] last_wdata;
        int          frozen;
        exp_t        e;
        seen_rd = 1'b0;
        seen_wr = 1'b0;
        last_addr = 32'd0;
        last_wdata = 32'd0;
        frozen = 0;
        forever begin
            @(negedge clk);
            if (rst && (rd_en || wr_en)) begin
                if (sram_rd_en) seen_rd = 1'b1;
                if (sram_wr_en) seen_wr = 1'b1;
                if (sram_rd_en || sram_wr_en) begin
                    last_addr  = sram_address;
                    last_wdata = sram_write_data;
                end
                if (freeze) begin
                    frozen = frozen + 1;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_completion actual=%h required=none", address);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_read) chk({e.name, "_read_data"}, read_data, e.data);
                        chk({e.name, "_sram_rd"}, {31'd0, seen_rd}, {31'd0, e.sram_rd});
                        chk({e.name, "_sram_wr"}, {31'd0, seen_wr}, {31'd0, e.sram_wr});
                        chk({e.name, "_frozen_cycles"}, frozen, e.frozen);
                        if (e.sram_rd || e.sram_wr) chk({e.name, "_sram_addr"}, last_addr, e.addr);
                        if (e.sram_wr) chk({e.name, "_sram_wdata"}, last_wdata, e.wdata);
                    end
                    seen_rd = 1'b0;
                    seen_wr = 1'b0;
                    frozen = 0;
                end
            end else begin
                seen_rd = 1'b0;
                seen_wr = 1'b0;
                frozen = 0;
            end
        end
    end

    // Issue one request, push its expectation and wait (bounded) for completion
    task automatic issue(input string name, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input bit exp_miss);
        exp_t e;
        int   budget;
        e.name    = name;
        e.is_read = rd && !wr;
        e.data    = exp_data;
        e.sram_rd = rd && !wr && exp_miss;
        e.sram_wr = wr;
        e.addr    = addr;
        e.wdata   = wdata;
        e.frozen  = (wr || exp_miss) ? LAT : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd_en = rd;
        wr_en = wr;
        address = addr;
        write_data = wdata;
        budget = 0;
        do begin
            @(negedge clk);
            budget = budget + 1;
        end while (freeze && budget < 50);
        if (freeze) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout actual=frozen required=complete", name);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        int budget;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        spur_ready = 1'b0;
        mem[32'd1024] = 32'h12345678;
        mem[32'd1280] = 32'h11112222;
        mem[32'd1536] = 32'h33334444;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_freeze", {31'd0, freeze}, 32'd0);
        chk("reset_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        chk("reset_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
        chk("reset_read_data", read_data, 32'd0);

        // Read miss then hit
        issue("rd_miss_1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b1);
        issue("rd_hit_1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b0);
        // Write miss, no allocate
        issue("wr_miss_1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b1);
        issue("rd_after_wr_miss_1028", 1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b1);
        // Write hit updates the cached word
        issue("wr_hit_1024", 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 32'd0, 1'b0);
        issue("rd_updated_1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b0);
        // LRU eviction in set 0
        issue("lru_rd_1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b0);
        issue("lru_rd_1280_fill", 1'b1, 1'b0, 32'd1280, 32'd0, 32'h11112222, 1'b1);
        issue("lru_rd_1024_hit", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b0);
        issue("lru_rd_1536_evict", 1'b1, 1'b0, 32'd1536, 32'd0, 32'h33334444, 1'b1);
        issue("lru_rd_1024_kept", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b0);
        issue("lru_rd_1280_evicted", 1'b1, 1'b0, 32'd1280, 32'd0, 32'h11112222, 1'b1);

        // sram_ready pulse while idle must be ignored
        @(posedge clk);
        #1;
        spur_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk);
        #1;
        spur_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        chk("idle_ready_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
        issue("rd_1024_after_spurious", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a read miss (1536 was just evicted)
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        address = 32'd1536;
        budget = 0;
        do begin
            @(negedge clk);
            budget = budget + 1;
        end while (!sram_rd_en && budget < 20);
        chk("midmiss_reached_read_miss", {31'd0, sram_rd_en}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midmiss_reset_freeze", {31'd0, freeze}, 32'd0);
        chk("midmiss_reset_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        issue("rd_1024_after_reset", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 1'b1);

        // Simultaneous read and write is a write; no allocation follows
        issue("rdwr_1032_as_write", 1'b1, 1'b1, 32'd1032, 32'h55AA55AA, 32'd0, 1'b1);
        issue("rd_1032_after_write", 1'b1, 1'b0, 32'd1032, 32'd0, 32'h55AA55AA, 1'b1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
